// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte sources; grant, Ack and tx_Start appear one cycle after a request in IDLE.
// The frame is timed by counting bit_Tick strobes; while busy, requesters wait by holding Valid and are not acked.
module uart_tx_arbiter #(
  parameter int FRAME_BITS    = 10,
  parameter int GAP_BITS      = 1,
  parameter int CNT_BITS      = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_Tick,
  input  logic       req0_Valid,
  input  logic [7:0] req0_Data,
  output logic       req0_Ack,
  input  logic       req1_Valid,
  input  logic [7:0] req1_Data,
  output logic       req1_Ack,
  output logic       tx_Start,
  output logic [7:0] tx_Data,
  output logic       tx_Busy,
  output logic       grant_Id
);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  localparam logic [CNT_BITS-1:0] FRAME_LAST = CNT_BITS'(FRAME_BITS - 1);
  localparam logic [CNT_BITS-1:0] GAP_LAST   = CNT_BITS'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_last_grant;
  logic                w_any_req;
  logic                w_winner;

  // Round-robin favours the source that did not win last time.
  always_comb begin
    w_any_req = req0_Valid | req1_Valid;
    if (req0_Valid && req1_Valid)
      w_winner = (PRIORITY_MODE != 0) ? 1'b0 : ~r_last_grant;
    else
      w_winner = req1_Valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      req0_Ack     <= 1'b0;
      req1_Ack     <= 1'b0;
      tx_Start     <= 1'b0;
      tx_Data      <= 8'h00;
      tx_Busy      <= 1'b0;
      grant_Id     <= 1'b0;
    end else begin
      req0_Ack <= 1'b0;
      req1_Ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state      <= START;
            tx_Data      <= w_winner ? req1_Data : req0_Data;
            grant_Id     <= w_winner;
            r_last_grant <= w_winner;
            req0_Ack     <= ~w_winner;
            req1_Ack     <= w_winner;
            tx_Start     <= 1'b1;
            tx_Busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_Tick) begin
            r_state  <= SEND;
            r_cnt    <= '0;
            tx_Start <= 1'b0;
          end
        end
        SEND: begin
          if (bit_Tick) begin
            if (r_cnt == FRAME_LAST) begin
              r_cnt <= '0;
              if (GAP_BITS > 0) begin
                r_state <= GAP;
              end else begin
                r_state <= IDLE;
                tx_Busy <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_BITS'(1);
            end
          end
        end
        GAP: begin
          if (bit_Tick) begin
            if (r_cnt == GAP_LAST) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              tx_Busy <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_BITS'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three instances (round-robin, fixed priority, no gap) share one stimulus.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_Tick;
  logic       req0_Valid, req1_Valid;
  logic [7:0] req0_Data, req1_Data;

  logic [2:0]      ack0, ack1, start, busy, gid;
  logic [2:0][7:0] txd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: round-robin, gap 1. Instance 1: fixed priority. Instance 2: round-robin, no gap.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_arbiter #(
      .FRAME_BITS(10),
      .GAP_BITS((g == 2) ? 0 : 1),
      .CNT_BITS(4),
      .PRIORITY_MODE((g == 1) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .bit_Tick  (bit_Tick),
      .req0_Valid(req0_Valid),
      .req0_Data (req0_Data),
      .req0_Ack  (ack0[g]),
      .req1_Valid(req1_Valid),
      .req1_Data (req1_Data),
      .req1_Ack  (ack1[g]),
      .tx_Start  (start[g]),
      .tx_Data   (txd[g]),
      .tx_Busy   (busy[g]),
      .grant_Id  (gid[g])
    );
  end

  typedef struct {
    logic        r0v;
    logic [7:0]  r0d;
    logic        tick;
    logic [12:0] exp;   // {ack0, ack1, start, busy, gid, data}
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic r0v, logic tick, logic a0, logic st, logic bz);
    vec_t v;
    v.r0v  = r0v;
    v.r0d  = 8'hA5;
    v.tick = tick;
    v.exp  = {a0, 1'b0, st, bz, 1'b0, 8'hA5};
    return v;
  endfunction

  function automatic logic [12:0] outs(int g);
    return {ack0[g], ack1[g], start[g], busy[g], gid[g], txd[g]};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int          n[3];
  logic        gg[3][4];
  logic [7:0]  gd[3][4];
  logic [2:0]  prev0, prev1;

  initial begin
    reset = 1'b1; bit_Tick = 1'b0;
    req0_Valid = 1'b0; req0_Data = 8'h00;
    req1_Valid = 1'b0; req1_Data = 8'h00;

    // Single req0 frame: tick on the grant edge is ignored, START stalls, 10 SEND ticks, 1 GAP tick.
    vecs[0]  = mk(1, 1, 1, 1, 1);
    vecs[1]  = mk(0, 0, 0, 1, 1);
    vecs[2]  = mk(0, 0, 0, 1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 1);
    for (int i = 4; i <= 8; i++)   vecs[i] = mk(0, 1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 1);
    for (int i = 10; i <= 14; i++) vecs[i] = mk(0, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 1);
    vecs[16] = mk(0, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 0, 0);

    step(); step();
    for (int g = 0; g < 3; g++) chk($sformatf("reset_outs[%0d]", g), 16'(outs(g)), 16'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 18; i++) begin
      req0_Valid = vecs[i].r0v;
      req0_Data  = vecs[i].r0d;
      bit_Tick   = vecs[i].tick;
      step();
      for (int g = 0; g < 2; g++)
        chk($sformatf("vec%0d_dut%0d", i, g), 16'(outs(g)), 16'(vecs[i].exp));
    end

    // Both sources held: round-robin alternates, fixed priority always picks req0.
    do_reset();
    req0_Valid = 1'b1; req0_Data = 8'h11;
    req1_Valid = 1'b1; req1_Data = 8'h22;
    bit_Tick = 1'b1;
    prev0 = '0; prev1 = '0;
    for (int g = 0; g < 3; g++) n[g] = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("both_acks_dut%0d", g), 16'(ack0[g] & ack1[g]), 16'h0);
        chk($sformatf("double_ack_dut%0d", g),
            16'((ack0[g] & prev0[g]) | (ack1[g] & prev1[g])), 16'h0);
        if ((ack0[g] | ack1[g]) && n[g] < 4) begin
          chk($sformatf("ack_vs_gid_dut%0d", g), 16'(ack1[g]), 16'(gid[g]));
          gg[g][n[g]] = gid[g];
          gd[g][n[g]] = txd[g];
          n[g]++;
        end
      end
      prev0 = ack0; prev1 = ack1;
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("grant_count_dut%0d", g), 16'(n[g] >= 4), 16'h1);
      for (int i = 0; i < 4 && i < n[g]; i++) begin
        logic eg;
        eg = (g == 1) ? 1'b0 : logic'(i % 2);
        chk($sformatf("grant%0d_id_dut%0d", i, g), 16'(gg[g][i]), 16'(eg));
        chk($sformatf("grant%0d_data_dut%0d", i, g), 16'(gd[g][i]), eg ? 16'h22 : 16'h11);
      end
    end

    // No ticks after a grant: START holds indefinitely, then resumes on a tick.
    req0_Valid = 1'b0; req1_Valid = 1'b0; bit_Tick = 1'b0;
    do_reset();
    req1_Valid = 1'b1; req1_Data = 8'h3C;
    step();
    for (int g = 0; g < 3; g++)
      chk($sformatf("stall_grant_dut%0d", g), 16'(outs(g)), 16'({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C}));
    req1_Valid = 1'b0;
    for (int c = 0; c < 20; c++) step();
    for (int g = 0; g < 3; g++)
      chk($sformatf("stall_hold_dut%0d", g), 16'({start[g], busy[g]}), 16'h3);
    bit_Tick = 1'b1;
    step();
    for (int g = 0; g < 3; g++)
      chk($sformatf("stall_resume_dut%0d", g), 16'({start[g], busy[g]}), 16'h1);

    // req1 raised mid-SEND: acked only after the frame (and gap) completes.
    bit_Tick = 1'b0;
    do_reset();
    req0_Valid = 1'b1; req0_Data = 8'hA5;
    bit_Tick = 1'b1;
    step();
    for (int g = 0; g < 3; g++) chk($sformatf("mid_req0_ack_dut%0d", g), 16'(ack0[g]), 16'h1);
    req0_Valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) begin
        req1_Valid = 1'b1; req1_Data = 8'h5A;
      end
      step();
      for (int g = 0; g < 3; g++)
        chk($sformatf("mid_req1_ack_k%0d_dut%0d", k, g), 16'(ack1[g]),
            16'((g == 2) ? (k == 12) : (k == 13)));
      if (k == 12) chk("mid_busy_idle_dut0", 16'(busy[0]), 16'h0);
      if (k == 13) chk("mid_req1_data_dut0", 16'({gid[0], txd[0]}), 16'h15A);
    end

    // Reset during SEND tick 5: outputs clear at once, req0 wins first afterwards.
    req1_Valid = 1'b0; bit_Tick = 1'b0;
    do_reset();
    req0_Valid = 1'b1; req0_Data = 8'hA5; bit_Tick = 1'b1;
    step();
    req0_Valid = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    chk("pre_reset_busy_dut0", 16'(busy[0]), 16'h1);
    reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk($sformatf("async_reset_dut%0d", g), 16'(outs(g)), 16'h0);
    req0_Valid = 1'b1; req0_Data = 8'h77;
    req1_Valid = 1'b1; req1_Data = 8'h88;
    step();
    for (int g = 0; g < 3; g++) chk($sformatf("held_reset_dut%0d", g), 16'(outs(g)), 16'h0);
    reset = 1'b0;
    step();
    for (int g = 0; g < 3; g++)
      chk($sformatf("post_reset_grant_dut%0d", g), 16'(outs(g)),
          16'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
